// File: rtl/dest_hazard_tracker.sv
// Carries destination/write-enable info through ID/EX, EX/MEM and MEM/WB, and detects load-use hazards.
// Latency: one cycle per stage. stall is combinational, one bubble per hazard; a flush overrides the stall.
`timescale 1ns/1ps
module dest_hazard_tracker #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [REG_W-1:0] ID_EX_Rd,
    output logic             ID_EX_RegWrite,
    output logic             ID_EX_MemRead,
    output logic [REG_W-1:0] EX_MEM_Rd,
    output logic             EX_MEM_RegWrite,
    output logic [REG_W-1:0] MEM_WB_Rd,
    output logic             MEM_WB_RegWrite,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    logic [REG_W-1:0] r_idex_rd;
    logic             r_idex_rw;
    logic             r_idex_mr;
    logic [REG_W-1:0] r_exmem_rd;
    logic             r_exmem_rw;
    logic [REG_W-1:0] r_memwb_rd;
    logic             r_memwb_rw;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs_match;
    logic w_rt_match;
    logic w_hazard;
    logic w_stall;
    logic w_bubble;

    // r0 is hardwired zero, so a load targeting it never creates a dependence.
    assign w_rs_match = (r_idex_rd == id_rs);
    assign w_rt_match = id_uses_rt & (r_idex_rd == id_rt);
    assign w_hazard   = id_valid & r_idex_mr & (r_idex_rd != '0) & (w_rs_match | w_rt_match);
    assign w_stall    = w_hazard & ~flush;
    assign w_bubble   = flush | w_stall | ~id_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex_rd   <= '0;
            r_idex_rw   <= 1'b0;
            r_idex_mr   <= 1'b0;
            r_exmem_rd  <= '0;
            r_exmem_rw  <= 1'b0;
            r_memwb_rd  <= '0;
            r_memwb_rw  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_memwb_rd <= r_exmem_rd;
            r_memwb_rw <= r_exmem_rw;
            r_exmem_rd <= r_idex_rd;
            r_exmem_rw <= r_idex_rw;
            if (w_bubble) begin
                r_idex_rd <= '0;
                r_idex_rw <= 1'b0;
                r_idex_mr <= 1'b0;
            end else begin
                r_idex_rd <= id_dest;
                r_idex_rw <= id_regwrite;
                r_idex_mr <= id_memread;
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ID_EX_Rd        = r_idex_rd;
    assign ID_EX_RegWrite  = r_idex_rw;
    assign ID_EX_MemRead   = r_idex_mr;
    assign EX_MEM_Rd       = r_exmem_rd;
    assign EX_MEM_RegWrite = r_exmem_rw;
    assign MEM_WB_Rd       = r_memwb_rd;
    assign MEM_WB_RegWrite = r_memwb_rw;
    assign stall           = w_stall;
    assign stall_count     = r_stall_cnt;

endmodule

// File: tb/tb_dest_hazard_tracker.sv
// Directed bench for dest_hazard_tracker; a 4-bit counter instance keeps the saturation case short.
`timescale 1ns/1ps
module tb_dest_hazard_tracker;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dest;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [REG_W-1:0] ID_EX_Rd;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MemRead;
    logic [REG_W-1:0] EX_MEM_Rd;
    logic             EX_MEM_RegWrite;
    logic [REG_W-1:0] MEM_WB_Rd;
    logic             MEM_WB_RegWrite;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    dest_hazard_tracker #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .stall(stall), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic urt, input logic [REG_W-1:0] d, input logic rw,
                         input logic mr, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_dest = d; id_regwrite = rw; id_memread = mr; flush = fl;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_idex_rd"}, 32'(ID_EX_Rd), 0);
        chk({tag, "_idex_rw"}, 32'(ID_EX_RegWrite), 0);
        chk({tag, "_idex_mr"}, 32'(ID_EX_MemRead), 0);
        chk({tag, "_exmem_rd"}, 32'(EX_MEM_Rd), 0);
        chk({tag, "_exmem_rw"}, 32'(EX_MEM_RegWrite), 0);
        chk({tag, "_memwb_rd"}, 32'(MEM_WB_Rd), 0);
        chk({tag, "_memwb_rw"}, 32'(MEM_WB_RegWrite), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_count"}, 32'(stall_count), 0);
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_dest = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        #3;
        chk_all_zero("por");
        #9 reset = 1'b0;

        // Independent ALU ops r3, r4, r5
        drive(1, 1, 2, 1, 3, 1, 0, 0); chk("alu3_stall", 32'(stall), 0); tick();
        drive(1, 1, 2, 1, 4, 1, 0, 0); chk("alu4_stall", 32'(stall), 0); tick();
        drive(1, 1, 2, 1, 5, 1, 0, 0); chk("alu5_stall", 32'(stall), 0); tick();
        chk("alu_memwb_rd", 32'(MEM_WB_Rd), 3);
        chk("alu_exmem_rd", 32'(EX_MEM_Rd), 4);
        chk("alu_idex_rd", 32'(ID_EX_Rd), 5);
        chk("alu_memwb_rw", 32'(MEM_WB_RegWrite), 1);
        chk("alu_exmem_rw", 32'(EX_MEM_RegWrite), 1);
        chk("alu_idex_rw", 32'(ID_EX_RegWrite), 1);

        // Load r8 then rs=8: one stall, MEM/WB forwarding afterwards
        drive(1, 1, 0, 0, 8, 1, 1, 0); chk("lu_load_stall", 32'(stall), 0); tick();
        drive(1, 8, 9, 1, 10, 1, 0, 0);
        chk("lu_stall", 32'(stall), 1);
        tick();
        chk("lu_bubble_rw", 32'(ID_EX_RegWrite), 0);
        chk("lu_exmem_rd", 32'(EX_MEM_Rd), 8);
        chk("lu_stall_drop", 32'(stall), 0);
        tick();
        chk("lu_dep_in_ex", 32'(ID_EX_Rd), 10);
        chk("lu_memwb_rd", 32'(MEM_WB_Rd), 8);
        chk("lu_count", 32'(stall_count), 1);

        // rt matches but is not a source
        drive(1, 1, 0, 0, 8, 1, 1, 0); tick();
        drive(1, 1, 8, 0, 11, 1, 0, 0);
        chk("rtnouse_stall", 32'(stall), 0);
        tick();
        chk("rtnouse_idex_rd", 32'(ID_EX_Rd), 11);

        // rt used as source does stall
        drive(1, 1, 0, 0, 8, 1, 1, 0); tick();
        drive(1, 2, 8, 1, 14, 1, 0, 0);
        chk("rtuse_stall", 32'(stall), 1);
        tick();
        chk("rtuse_count", 32'(stall_count), 2);
        tick();

        // Flush beats hazard
        drive(1, 1, 0, 0, 8, 1, 1, 0); tick();
        drive(1, 8, 0, 0, 12, 1, 0, 1);
        chk("flush_stall", 32'(stall), 0);
        tick();
        chk("flush_idex_rd", 32'(ID_EX_Rd), 0);
        chk("flush_idex_rw", 32'(ID_EX_RegWrite), 0);
        chk("flush_count", 32'(stall_count), 2);

        // Load to r0 is stored as given but never stalls
        drive(1, 1, 0, 0, 0, 1, 1, 0); tick();
        chk("r0_idex_rw", 32'(ID_EX_RegWrite), 1);
        chk("r0_idex_mr", 32'(ID_EX_MemRead), 1);
        drive(1, 0, 0, 1, 13, 1, 0, 0);
        chk("r0_stall", 32'(stall), 0);
        tick();
        chk("r0_idex_rd", 32'(ID_EX_Rd), 13);

        // Fill with 5,6,7 then reset away from an edge
        drive(1, 1, 2, 1, 5, 1, 0, 0); tick();
        drive(1, 1, 2, 1, 6, 1, 0, 0); tick();
        drive(1, 1, 2, 1, 7, 1, 0, 0); tick();
        chk("fill_memwb_rd", 32'(MEM_WB_Rd), 5);
        chk("fill_exmem_rd", 32'(EX_MEM_Rd), 6);
        chk("fill_idex_rd", 32'(ID_EX_Rd), 7);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        #2 reset = 1'b0;

        // Self-dependent loads stall every other cycle until the counter saturates
        drive(1, 8, 0, 0, 8, 1, 1, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 19) chk("sat_mid_count", 32'(stall_count), 10);
        end
        chk("sat_pre_count", 32'(stall_count), 15);
        chk("sat_pre_stall", 32'(stall), 0);
        tick();
        chk("sat_stall", 32'(stall), 1);
        chk("sat_full_count", 32'(stall_count), 15);
        tick();
        chk("sat_hold_count", 32'(stall_count), 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dest_hazard_tracker.md
Name: dest_hazard_tracker

Overview:
- Producer side of the EX forwarding interface. Carries each instruction's destination-register and write-enable information through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the EX_MEM_Rd/RegWrite and MEM_WB_Rd/RegWrite signals that the forwarding unit consumes.
- Detects load-use hazards that forwarding cannot cover, inserts one bubble for each, and counts stall cycles for performance monitoring.

Parameters:
- REG_W, 5: register-index width.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_W  ID source register 1.
- id_rt  in  REG_W  ID source register 2.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_dest  in  REG_W  ID instruction's destination register.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  branch/jump resolved in EX; squash the ID instruction.
- ID_EX_Rd  out  REG_W  destination held in EX.
- ID_EX_RegWrite  out  1
- ID_EX_MemRead  out  1
- EX_MEM_Rd  out  REG_W
- EX_MEM_RegWrite  out  1
- MEM_WB_Rd  out  REG_W
- MEM_WB_RegWrite  out  1
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- stall_count  out  CNT_W  cycles on which stall was asserted.

Behaviour:
- Reset (asynchronous): all Rd outputs are 0, all RegWrite/MemRead outputs are 0, stall_count is 0.
- stall is 0 while reset is held, because its inputs are all 0.
- hazard = id_valid & ID_EX_MemRead & (ID_EX_Rd != 0) & ((ID_EX_Rd == id_rs) | (id_uses_rt & ID_EX_Rd == id_rt)).
- stall = hazard & ~flush. A flush squashes the dependent instruction, so no stall is taken.
- Every rising edge, advance all three stages unconditionally:
  - MEM/WB takes EX/MEM.
  - EX/MEM takes ID/EX.
- ID/EX load on each edge:
  - If flush, stall, or ~id_valid: load a bubble (Rd = 0, RegWrite = 0, MemRead = 0).
  - Otherwise: load id_dest, id_regwrite and id_memread.
- Destination 0:
  - If id_regwrite = 1 with id_dest = 0, store it as given.
  - The consumer already masks Rd = 0.
  - For hazard purposes Rd = 0 never stalls.
- Load-use latency:
  - One stall cycle per hazard.
  - The next cycle the load sits in EX/MEM with ID/EX holding a bubble, so hazard drops unless a new load is in EX.
  - The dependent instruction then gets MEM_WB forwarding on its EX cycle.
- stall_count increments by 1 on each edge where stall = 1 and saturates at all-ones (no wrap).
- Reset mid-operation clears all stage registers and the counter immediately, without waiting for a clock edge.
- Simultaneous flush and hazard: flush wins; stall = 0, a bubble enters EX, and the counter is unchanged.

Test Plan:
- Reset asserted mid-stream with stages full (Rd = 5, 6, 7) -> all outputs 0 immediately, before the next edge; stall_count = 0.
- Three back-to-back ALU ops writing r3, r4, r5, no dependences -> after 3 edges MEM_WB_Rd = 3, EX_MEM_Rd = 4, ID_EX_Rd = 5, all RegWrite = 1; stall never asserted.
- Load r8 followed by an instruction with rs = 8 -> stall = 1 for exactly one cycle.
  - Next cycle: ID_EX_RegWrite = 0 and EX_MEM_Rd = 8.
  - The cycle after: the dependent instruction is in EX with MEM_WB_Rd = 8.
  - stall_count = 1.
- Load r8, then an instruction with rt = 8 and id_uses_rt = 0 -> no stall.
- Load r8, then rs = 8 with flush = 1 in the same cycle -> stall = 0, bubble enters EX, stall_count unchanged.
- Load r0, then rs = 0 -> no stall.
- Force the counter to 16'hFFFF (CNT_W = 16) via repeated load-use pairs -> the next stall leaves stall_count = 16'hFFFF.
